// File: rtl/serial_full_adder_if.sv
// Bundle for the bit-serial adder: operand/start request from the
// master side, serial and parallel results back from the adder.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             sum_bit;
    logic             sum_bit_valid;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, sum_bit, sum_bit_valid, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, sum_bit, sum_bit_valid, done, sum, cout
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, processing
// one operand bit per clock LSB first, with a registered parallel result.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_full_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             sum_bit_q;
    logic             valid_q;
    logic             done_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] acc_next;

    // Full-adder cell on the current LSBs and the accumulator with the new bit at the MSB
    always_comb begin
        s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        c_bit    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        // Shift-then-patch keeps this legal when WIDTH is 1
        acc_next = acc >> 1;
        acc_next[WIDTH-1] = s_bit;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            acc       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            sum_bit_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        count <= '0;
                        acc   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry     <= c_bit;
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    acc       <= acc_next;
                    sum_bit_q <= s_bit;
                    valid_q   <= 1'b1;
                    count     <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        sum_q  <= acc_next;
                        cout_q <= c_bit;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.sum_bit       = sum_bit_q;
    assign bus.sum_bit_valid = valid_q;
    assign bus.done          = done_q;
    assign bus.sum           = sum_q;
    assign bus.cout          = cout_q;
endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: a cycle-level behavioural
// model built on plain a+b+cin arithmetic, plus directed literal checks.
module tb_serial_full_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   armed;

    serial_full_adder_if #(.WIDTH(8)) bus8 ();
    serial_full_adder_if #(.WIDTH(3)) bus3 ();

    serial_full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_full_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per DUT: k = edges since accepting edge (-1 when idle)
    int          m_k    [2];
    logic [63:0] m_res  [2];
    logic        m_bit  [2];
    logic [31:0] m_sum  [2];
    logic        m_cout [2];

    task automatic model_step(input int i, input int w, input logic r, input logic s,
                              input logic [31:0] a, input logic [31:0] b, input logic c);
        if (r) begin
            m_k[i] = -1; m_sum[i] = '0; m_cout[i] = 1'b0; m_bit[i] = 1'b0;
        end else if (m_k[i] == -1) begin
            if (s) begin
                m_k[i]   = 0;
                m_res[i] = 64'(a) + 64'(b) + 64'(c);
            end
        end else begin
            m_k[i] = m_k[i] + 1;
            if (m_k[i] <= w) m_bit[i] = m_res[i][m_k[i]-1];
            if (m_k[i] == w) begin
                m_sum[i]  = 32'(m_res[i] & ((64'd1 << w) - 64'd1));
                m_cout[i] = m_res[i][w];
            end
            if (m_k[i] == w + 1) m_k[i] = -1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8, rst, bus8.start, 32'(bus8.a), 32'(bus8.b), bus8.cin);
        model_step(1, 3, rst, bus3.start, 32'(bus3.a), 32'(bus3.b), bus3.cin);
    end

    task automatic check_dut(input int i, input int w, input string nm, input logic busy,
                             input logic done, input logic valid, input logic sbit,
                             input logic cout, input logic [31:0] sum);
        logic        e_busy, e_done, e_valid, e_bit, a_bit;
        logic [36:0] exp_v, act_v;
        e_busy  = (m_k[i] >= 0);
        e_done  = (m_k[i] == w);
        e_valid = (m_k[i] >= 1) && (m_k[i] <= w);
        e_bit   = e_valid ? m_bit[i] : 1'b0;
        a_bit   = e_valid ? sbit : 1'b0;
        exp_v   = {e_busy, e_done, e_valid, e_bit, m_cout[i], m_sum[i]};
        act_v   = {busy, done, valid, a_bit, cout, sum};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle t=%0t: got busy=%b done=%b valid=%b bit=%b cout=%b sum=%h, expected busy=%b done=%b valid=%b bit=%b cout=%b sum=%h",
                     nm, $time, busy, done, valid, a_bit, cout, sum,
                     e_busy, e_done, e_valid, e_bit, m_cout[i], m_sum[i]);
        end
    endtask

    // Compare process: every cycle once reset has been applied
    always @(negedge clk) begin
        if (armed) begin
            check_dut(0, 8, "w8", bus8.busy, bus8.done, bus8.sum_bit_valid, bus8.sum_bit,
                      bus8.cout, 32'(bus8.sum));
            check_dut(1, 3, "w3", bus3.busy, bus3.done, bus3.sum_bit_valid, bus3.sum_bit,
                      bus3.cout, 32'(bus3.sum));
        end
    end

    // Serial bit collectors and done-pulse counters
    logic [7:0] ser8;
    logic [2:0] ser3;
    int         dcount8;
    always @(negedge clk) begin
        if (bus8.sum_bit_valid) ser8 = {bus8.sum_bit, ser8[7:1]};
        if (bus3.sum_bit_valid) ser3 = {bus3.sum_bit, ser3[2:1]};
        if (bus8.done) dcount8++;
    end

    task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Wait for done on the 8-bit DUT; start was raised by the caller.
    // xs >= 0 re-pulses start for one cycle to be sampled at edge E(xs).
    task automatic wait_done8(output int cyc, input int xs, input bit hold);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) bus8.start = 1'b0;
            if (xs >= 0 && cyc == xs) bus8.start = 1'b1;
            if (xs >= 0 && cyc == xs + 1) bus8.start = 1'b0;
            if (bus8.done) break;
        end
        if (!bus8.done) begin
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] e_sum, input logic e_cout);
        int cyc;
        bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
        ser8 = '0; dcount8 = 0;
        wait_done8(cyc, -1, 1'b0);
        lit({nm, "_latency"}, 64'(cyc), 64'd9);
        lit({nm, "_sum"}, 64'(bus8.sum), 64'(e_sum));
        lit({nm, "_cout"}, 64'(bus8.cout), 64'(e_cout));
        @(negedge clk);
        lit({nm, "_serial"}, 64'(ser8), 64'(e_sum));
    endtask

    initial begin
        int cyc;
        checks = 0; errors = 0; armed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_k[i] = -1; m_res[i] = '0; m_bit[i] = 1'b0; m_sum[i] = '0; m_cout[i] = 1'b0;
        end
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;
        ser8 = '0; ser3 = '0; dcount8 = 0;
        rst = 1'b1;
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit("reset_busy", 64'(bus8.busy), 64'd0);
        lit("reset_sum", 64'({bus8.cout, bus8.sum}), 64'd0);

        op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        lit("zero_dones", 64'(dcount8), 64'd1);
        op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

        // Second start pulse while busy must be ignored
        bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.cin = 1'b1; bus8.start = 1'b1; dcount8 = 0;
        wait_done8(cyc, 3, 1'b0);
        lit("a5_latency", 64'(cyc), 64'd9);
        lit("a5_result", 64'({bus8.cout, bus8.sum}), 64'h100);
        repeat (12) @(negedge clk);
        lit("a5_dones", 64'(dcount8), 64'd1);
        lit("a5_held", 64'({bus8.cout, bus8.sum}), 64'h100);

        // Mid-operation reset at E4
        bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.cin = 1'b0; bus8.start = 1'b1; dcount8 = 0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit("abort_outputs", 64'({bus8.busy, bus8.done, bus8.sum_bit_valid, bus8.sum_bit,
                                  bus8.cout, bus8.sum}), 64'd0);
        repeat (12) @(negedge clk);
        lit("abort_dones", 64'(dcount8), 64'd0);
        op8("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // start held across two operations
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        wait_done8(cyc, -1, 1'b1);
        lit("hold1_result", 64'({bus8.cout, bus8.sum}), 64'h046);
        bus8.a = 8'h80; bus8.b = 8'h80;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 9) lit("hold_sum_kept", 64'(bus8.sum), 64'h46);
            if (bus8.done) break;
        end
        bus8.start = 1'b0;
        lit("hold_spacing", 64'(cyc), 64'd10);
        lit("hold2_result", 64'({bus8.cout, bus8.sum}), 64'h100);
        repeat (3) @(negedge clk);

        // Exhaustive WIDTH=3 sweep
        for (int av = 0; av < 8; av++) begin
            for (int bv = 0; bv < 8; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    bus3.a = 3'(av); bus3.b = 3'(bv); bus3.cin = 1'(cv);
                    bus3.start = 1'b1; ser3 = '0;
                    cyc = 0;
                    while (cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                        bus3.start = 1'b0;
                        if (bus3.done) break;
                    end
                    lit("w3_latency", 64'(cyc), 64'd4);
                    lit("w3_sum", 64'({bus3.cout, bus3.sum}), 64'(av + bv + cv));
                    @(negedge clk);
                    lit("w3_serial", 64'(ser3), 64'((av + bv + cv) % 8));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
